// File: rtl/shift_add_mul_ctrl.sv
// ---------------------------------------------------------------------------
// shift_add_mul_ctrl
//
// Sequential 8x8 unsigned shift-and-add multiplier controller. It does not own
// an adder. It drives the two operands of a shared external 8-bit adder
// (carry-in tied 0) and recovers the carry-out from the returned sum.
//
// One multiplier bit is consumed per RUN cycle, LSB first. The partial
// product's upper byte lives in acc_hi. Its lower bits shift into acc_lo from
// the top, while the not-yet-consumed multiplier bits shift out at the bottom.
//
// Parameters
//   DONE_PULSE  1: done is high for the single DONE cycle only
//               0: done stays high until the next accepted start
//
// Optional build macro
//   MUL_EARLY_EXIT_EN  finish as soon as no set multiplier bits remain; the
//                      product is the same, only the RUN length changes
//
// Ports
//   clk     in   1   clock, rising edge
//   rst_n   in   1   synchronous active-low reset
//   start   in   1   request a multiply (accepted in IDLE or DONE)
//   A       in   8   multiplicand, sampled on accept
//   B       in   8   multiplier, sampled on accept
//   add_A   out  8   external adder operand A
//   add_B   out  8   external adder operand B
//   add_Y   in   8   external adder sum (combinational)
//   busy    out  1   multiply in progress
//   done    out  1   product valid indication
//   P       out  16  product A*B
// ---------------------------------------------------------------------------
module shift_add_mul_ctrl #(
    parameter int DONE_PULSE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [7:0]  add_A,
    output logic [7:0]  add_B,
    input  logic [7:0]  add_Y,
    output logic        busy,
    output logic        done,
    output logic [15:0] P
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_mcand;
    logic [7:0]  r_acc_hi;
    logic [7:0]  r_acc_lo;
    logic [2:0]  r_count;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_p;

    logic        w_carry;
    logic [15:0] w_acc_next;
    logic        w_last;
    logic [15:0] w_p_final;

    // With Cin = 0, the sum wraps below operand A exactly when a carry left
    // the adder.
    assign w_carry = (add_Y < add_A);

    assign w_acc_next = r_acc_lo[0] ? {w_carry, add_Y, r_acc_lo[7:1]}
                                    : {1'b0, r_acc_hi, r_acc_lo[7:1]};

`ifdef MUL_EARLY_EXIT_EN
    logic [6:0]  w_remain_mask;
    logic        w_remain_zero;
    logic [2:0]  w_shamt;

    // After this cycle's shift, the low (7-count) bits of acc_lo[7:1] are
    // multiplier bits that have not been consumed yet.
    assign w_remain_mask = 7'h7F >> r_count;
    assign w_remain_zero = ((r_acc_lo[7:1] & w_remain_mask) == 7'd0);
    assign w_last        = (r_count == 3'd7) || w_remain_zero;
    // Stopping early leaves the product (7-count) places too far left. It
    // still has to be shifted down into its final position.
    assign w_shamt       = 3'd7 - r_count;
    assign w_p_final     = w_acc_next >> w_shamt;
`else
    assign w_last    = (r_count == 3'd7);
    assign w_p_final = w_acc_next;
`endif

    // The adder operands come from registered state only. This keeps the
    // add_A -> add_Y -> carry path free of combinational loops.
    always_comb begin
        add_A = 8'h00;
        add_B = 8'h00;
        if (r_state == S_RUN) begin
            add_A = r_acc_hi;
            add_B = r_acc_lo[0] ? r_mcand : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_mcand  <= 8'h00;
            r_acc_hi <= 8'h00;
            r_acc_lo <= 8'h00;
            r_count  <= 3'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_p      <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mcand  <= A;
                        r_acc_hi <= 8'h00;
                        r_acc_lo <= B;
                        r_count  <= 3'd0;
                        r_state  <= S_RUN;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                    end
                end

                S_RUN: begin
                    {r_acc_hi, r_acc_lo} <= w_acc_next;
                    r_count              <= r_count + 3'd1;
                    if (w_last) begin
                        r_p     <= w_p_final;
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end

                S_DONE: begin
                    // Pulse mode drops done when leaving DONE. Hold mode keeps
                    // it up until an accept clears it.
                    if (DONE_PULSE != 0) begin
                        r_done <= 1'b0;
                    end
                    if (start) begin
                        // Back-to-back accept, no idle bubble.
                        r_mcand  <= A;
                        r_acc_hi <= 8'h00;
                        r_acc_lo <= B;
                        r_count  <= 3'd0;
                        r_state  <= S_RUN;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign P    = r_p;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_add_mul_ctrl
//
// Drives two instances with identical stimulus. dut0 uses DONE_PULSE=1 and
// dut1 uses DONE_PULSE=0. Each instance has its own adder model.
//
// A transaction-level model (product = a*b, partial sums from plain
// arithmetic) predicts every output on every cycle. Directed vectors with
// hand-computed literals pin that model.
// ---------------------------------------------------------------------------
module tb_shift_add_mul_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  A_i;
    logic [7:0]  B_i;

    logic [7:0]  add_A0, add_B0, add_Y0;
    logic        busy0, done0;
    logic [15:0] P0;
    logic [7:0]  add_A1, add_B1, add_Y1;
    logic        busy1, done1;
    logic [15:0] P1;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    int          m_phase;   // 0 idle, 1 running, 2 done cycle
    int          m_k;       // multiplier bits consumed so far
    int          m_n;       // RUN cycles this operation takes
    logic [7:0]  m_a, m_b;
    logic [15:0] m_p;
    logic        m_hold;

    logic [7:0]  seq [8];

    assign add_Y0 = add_A0 + add_B0;
    assign add_Y1 = add_A1 + add_B1;

    shift_add_mul_ctrl #(.DONE_PULSE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A_i), .B(B_i),
        .add_A(add_A0), .add_B(add_B0), .add_Y(add_Y0),
        .busy(busy0), .done(done0), .P(P0)
    );

    shift_add_mul_ctrl #(.DONE_PULSE(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A_i), .B(B_i),
        .add_A(add_A1), .add_B(add_B1), .add_Y(add_Y1),
        .busy(busy1), .done(done1), .P(P1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_cycles(input logic [7:0] b);
        int n;
`ifdef MUL_EARLY_EXIT_EN
        n = 1;
        for (int i = 0; i < 8; i++) if (b[i]) n = i + 1;
`else
        n = 8;
`endif
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic accept_model();
        m_a    = A_i;
        m_b    = B_i;
        m_k    = 0;
        m_n    = exp_cycles(B_i);
        m_hold = 1'b0;
        m_phase = 1;
    endtask

    // Advance the model with the inputs the DUT samples at the coming edge.
    task automatic model_step();
        if (!rst_n) begin
            m_phase = 0; m_k = 0; m_p = 16'h0; m_hold = 1'b0;
            m_a = 8'h0; m_b = 8'h0;
        end else begin
            case (m_phase)
                0: if (start) accept_model();
                1: begin
                    m_k = m_k + 1;
                    if (m_k == m_n) begin
                        m_p     = 16'(m_a * m_b);
                        m_phase = 2;
                        m_hold  = 1'b1;
                    end
                end
                default: if (start) accept_model(); else m_phase = 0;
            endcase
        end
    endtask

    task automatic compare();
        logic [15:0] partial;
        logic [7:0]  ea, eb;
        ea = 8'h00;
        eb = 8'h00;
        if (m_phase == 1) begin
            partial = 16'(m_a * (m_b & 8'((1 << m_k) - 1)));
            ea = 8'(partial >> m_k);
            eb = m_b[m_k] ? m_a : 8'h00;
        end
        chk("add_A", add_A0, ea);
        chk("add_B", add_B0, eb);
        chk("busy", busy0, m_phase == 1);
        chk("done_pulse", done0, m_phase == 2);
        chk("P", P0, m_p);
        chk("busy_hold", busy1, m_phase == 1);
        chk("done_hold", done1, m_hold);
        chk("P_hold", P1, m_p);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    // Runs one multiply and stops in its DONE cycle. With keep_start set,
    // start stays high and A/B are scrambled during RUN; both must be ignored.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit keep_start,
                          output int cnt, output logic [15:0] p,
                          output logic first_busy, output logic first_done1);
        int guard;
        A_i = a; B_i = b; start = 1'b1;
        tick();
        first_busy  = busy0;
        first_done1 = done1;
        if (keep_start) begin
            A_i = ~a; B_i = ~b;
        end else begin
            start = 1'b0;
        end
        cnt = 0;
        guard = 0;
        while (done0 !== 1'b1 && guard < 40) begin
            if (busy0 === 1'b1) begin
                if (cnt < 8) seq[cnt] = add_B0;
                cnt++;
            end
            tick();
            guard++;
        end
        chk("op_timeout", (guard < 40) ? 32'd1 : 32'd0, 32'd1);
        p = P0;
    endtask

    initial begin
        int          cnt;
        logic [15:0] p;
        logic        fb, fd;
        logic [7:0]  exp_seq [8];
        logic [7:0]  ra, rb;

        exp_seq[0] = 8'h0D; exp_seq[1] = 8'h0D; exp_seq[2] = 8'h00; exp_seq[3] = 8'h0D;
        exp_seq[4] = 8'h00; exp_seq[5] = 8'h00; exp_seq[6] = 8'h00; exp_seq[7] = 8'h00;

        m_phase = 0; m_k = 0; m_n = 8; m_a = 0; m_b = 0; m_p = 0; m_hold = 0;
        rst_n = 1'b0; start = 1'b0; A_i = 8'h00; B_i = 8'h00;
        tick();
        tick();
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done1, 1'b0);
        chk("rst_P", P0, 16'h0);
        rst_n = 1'b1;
        tick();

        // FF * FF: eight RUN cycles, then a single-cycle done pulse.
        run_op(8'hFF, 8'hFF, 1'b0, cnt, p, fb, fd);
        chk("ff_cycles", cnt, 32'd8);
        chk("ff_P", p, 16'hFE01);
        tick();
        chk("ff_pulse_low", done0, 1'b0);
        chk("ff_hold_high", done1, 1'b1);

        // 0D * 0B: add_B follows B bits LSB first.
        run_op(8'h0D, 8'h0B, 1'b0, cnt, p, fb, fd);
        chk("0d_cycles", cnt, exp_cycles(8'h0B));
        chk("0d_P", p, 16'h008F);
        for (int i = 0; i < 8; i++)
            if (i < cnt) chk($sformatf("0d_addB%0d", i), seq[i], exp_seq[i]);

        // Held done must survive 10 idle cycles and drop on the next accept.
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_idle", done1, 1'b1);
        end
        run_op(8'h55, 8'h00, 1'b0, cnt, p, fb, fd);
        chk("hold_drop", fd, 1'b0);
        chk("b0_cycles", cnt, exp_cycles(8'h00));
        chk("b0_P", p, 16'h0000);

        run_op(8'h80, 8'h03, 1'b0, cnt, p, fb, fd);
        chk("b3_cycles", cnt, exp_cycles(8'h03));
        chk("b3_P", p, 16'h0180);

        run_op(8'h12, 8'h80, 1'b0, cnt, p, fb, fd);
        chk("b80_cycles", cnt, 32'd8);
        chk("b80_P", p, 16'h0900);

        // start held high: 3*5, then 7*9 accepted straight out of DONE.
        tick();
        run_op(8'h03, 8'h05, 1'b1, cnt, p, fb, fd);
        chk("bb1_P", p, 16'h000F);
        run_op(8'h07, 8'h09, 1'b1, cnt, p, fb, fd);
        chk("bb_no_idle", fb, 1'b1);
        chk("bb2_P", p, 16'h003F);
        start = 1'b0;
        tick();

        // Reset during the 4th RUN cycle of AA*55, with start high.
        A_i = 8'hAA; B_i = 8'h55; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0; start = 1'b1;
        tick();
        chk("midrst_busy", busy0, 1'b0);
        chk("midrst_done", done0, 1'b0);
        chk("midrst_done_hold", done1, 1'b0);
        chk("midrst_P", P0, 16'h0000);
        chk("midrst_addA", add_A0, 8'h00);
        rst_n = 1'b1; start = 1'b0;
        tick();
        run_op(8'h02, 8'h03, 1'b0, cnt, p, fb, fd);
        chk("after_rst_P", p, 16'h0006);

        // A few random operands; the model checks them every cycle.
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_op(ra, rb, 1'b0, cnt, p, fb, fd);
            chk("rnd_P", p, 16'(ra * rb));
        end
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shift_add_mul_ctrl.md
SHIFT_ADD_MUL_CTRL -- requirements
Module: shift_add_mul_ctrl

Interface
REQ-001 Parameter DONE_PULSE, default 1: 1 = done is a one-cycle pulse; 0 = done is held until the next accepted start.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 start  input  1  request to multiply A by B.
REQ-005 A  input  8  multiplicand, unsigned; sampled only when start is accepted.
REQ-006 B  input  8  multiplier, unsigned; sampled only when start is accepted.
REQ-007 add_A  output  8  operand A to the shared external 8-bit adder (Cin tied 0).
REQ-008 add_B  output  8  operand B to the shared external 8-bit adder.
REQ-009 add_Y  input  8  combinational sum returned by the external adder.
REQ-010 busy  output  1  high while a multiply is in progress.
REQ-011 done  output  1  product-valid indication.
REQ-012 P  output  16  unsigned product A*B.

Function
REQ-013 States: IDLE, RUN, DONE; encoding is free.
REQ-014 Start is accepted on an edge where start=1 and the state is IDLE or DONE. On accept:
- mcand <= A, acc_hi <= 0, acc_lo <= B, count <= 0
- state -> RUN
REQ-015 Start in RUN is ignored, with no effect on the operation in progress.
REQ-016 Adder drive:
- In RUN: add_A = acc_hi; add_B = mcand if acc_lo[0]=1, else 8'h00.
- In IDLE/DONE: add_A = add_B = 8'h00.
REQ-017 Carry out of the adder is derived as carry = (add_Y < add_A) (unsigned compare); no carry port exists.
REQ-018 Each RUN edge:
- If acc_lo[0]=1: {acc_hi,acc_lo} <= {carry, add_Y, acc_lo[7:1]}.
- Else: {acc_hi,acc_lo} <= {1'b0, acc_hi, acc_lo[7:1]}.
- count <= count+1.
REQ-019 RUN -> DONE on the edge where count=7 (eight RUN cycles), unless REQ-027 applies.
REQ-020 P <= {acc_hi,acc_lo} final value on the RUN->DONE edge; P holds until the next RUN->DONE edge.
REQ-021 busy = 1 in RUN only; busy = 0 in IDLE and DONE.
REQ-022 done output:
- DONE_PULSE=1: done = 1 only in the single DONE cycle.
- DONE_PULSE=0: done rises on entering DONE and stays high through IDLE until the next accepted start, where it drops on that edge.
REQ-023 DONE -> IDLE after one cycle if start=0; DONE -> RUN if start=1 (back-to-back; no idle bubble).
REQ-024 Latency, baseline: start accepted at edge t0 -> busy from t0 to t8 -> done and valid P in the cycle after t8.

Reset
REQ-025 On an edge with rst_n=0, every state element clears regardless of state, including mid-RUN:
- state = IDLE; busy = 0; done = 0; P = 16'h0000
- acc_hi, acc_lo, mcand, count = 0
- add_A = add_B = 0
REQ-026 An operation interrupted by reset is discarded. No done is produced for it, and start is not accepted on any edge where rst_n=0.

Configuration
REQ-027 Macro MUL_EARLY_EXIT_EN, when defined:
- Each RUN edge evaluates the multiplier bits remaining after the shift, i.e. acc_lo[7:1] masked to its (7-count) unprocessed positions.
- If these are all zero, or count=7, the block goes to DONE.
- P is loaded with the updated {acc_hi,acc_lo} shifted right by (7-count).
- RUN cycle count = max(1, position of the most significant set bit of B, plus 1).
REQ-028 MUL_EARLY_EXIT_EN undefined: always exactly eight RUN cycles per REQ-019; the product is identical in both builds.

Verification
REQ-029 A=8'hFF, B=8'hFF, start one cycle -> busy for 8 cycles, then done=1 one cycle, P=16'hFE01.
REQ-030 A=8'h0D, B=8'h0B -> P=16'h008F; add_B alternates 8'h0D / 8'h00 following the B bits LSB first (1,1,0,1,0,0,0,0).
REQ-031 start held high continuously with A=3, B=5, then A=7, B=9 presented in the DONE cycle:
- P=16'h000F, then P=16'h003F
- no IDLE cycle between operations
- start during RUN has no effect
REQ-032 rst_n=0 on the 4th RUN cycle of A=8'hAA, B=8'h55 -> next cycle: state IDLE, busy=0, done=0, P=0. A fresh start of A=2, B=3 then gives P=16'h0006.
REQ-033 MUL_EARLY_EXIT_EN defined:
- B=8'h00 -> 1 RUN cycle, P=0
- B=8'h03, A=8'h80 -> 2 RUN cycles, P=16'h0180
- B=8'h80 -> 8 RUN cycles
REQ-034 DONE_PULSE=0: done stays high across 10 idle cycles after completion and drops on the edge accepting the next start.
